// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module : muldiv_pkg
// Brief  : Shared width default, RV32M funct3 codes and FSM encoding for the
//          iterative multiply/divide unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int DEFAULT_XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_divrem(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_div_core.sv
// ============================================================================
// Module : muldiv_div_core
// Brief  : Restoring divider on unsigned magnitudes, one quotient bit per
//          step. Built only when MULDIV_DIV_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quo_nxt_o,
    output logic [XLEN-1:0] rem_nxt_o
);

    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_fits;

    // Partial remainder stays below the divisor, so XLEN+1 bits hold the shift.
    assign w_shift   = {rem_q, quo_q[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, dsr_q};
    assign w_fits    = ~w_diff[XLEN];
    assign rem_nxt_o = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign quo_nxt_o = {quo_q[XLEN-2:0], w_fits};

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dsr_d = dsr_q;
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dsr_d = divisor_i;
        end else if (step_i) begin
            rem_d = rem_nxt_o;
            quo_d = quo_nxt_o;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dsr_q <= dsr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module : muldiv_unit
// Brief  : Iterative RV32M multiply/divide unit, one bit per cycle. Define
//          MULDIV_DIV_EN to build the divider; otherwise div/rem return 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;

    logic              w_a_signed, w_b_signed;
    logic              w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_prod_step;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_mul_res;
    logic [XLEN-1:0]   w_run_res;

    assign w_a_signed = is_divrem(funct3) ? ~funct3[0] : (funct3 != F3_MULHU);
    assign w_b_signed = is_divrem(funct3) ? ~funct3[0]
                                          : (funct3 == F3_MUL || funct3 == F3_MULH);
    assign w_a_neg    = w_a_signed & rs1_val[XLEN-1];
    assign w_b_neg    = w_b_signed & rs2_val[XLEN-1];
    assign w_a_mag    = w_a_neg ? -rs1_val : rs1_val;
    assign w_b_mag    = w_b_neg ? -rs2_val : rs2_val;

    // Product register: high half accumulates, low half shifts the multiplier out.
    assign w_mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]}
                       + {1'b0, (prod_q[0] ? mcand_q : {XLEN{1'b0}})};
    assign w_prod_step = {w_mul_sum, prod_q[XLEN-1:1]};
    assign w_prod_fix  = (sa_q ^ sb_q) ? -w_prod_step : w_prod_step;
    assign w_mul_res   = (op_q == F3_MUL) ? w_prod_fix[XLEN-1:0]
                                          : w_prod_fix[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
    logic            w_div_load, w_div_step;
    logic [XLEN-1:0] w_quo_nxt, w_rem_nxt;
    logic [XLEN-1:0] w_div_res;

    muldiv_div_core #(
        .XLEN (XLEN)
    ) u_div_core (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_div_load),
        .step_i     (w_div_step),
        .dividend_i (w_a_mag),
        .divisor_i  (w_b_mag),
        .quo_nxt_o  (w_quo_nxt),
        .rem_nxt_o  (w_rem_nxt)
    );

    // Remainder follows the dividend's sign; quotient follows sign(A)^sign(B).
    assign w_div_res = op_q[1] ? (sa_q ? -w_rem_nxt : w_rem_nxt)
                               : ((sa_q ^ sb_q) ? -w_quo_nxt : w_quo_nxt);
    assign w_run_res = is_divrem(op_q) ? w_div_res : w_mul_res;
`else
    assign w_run_res = w_mul_res;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rd_out_d = rd_out_q;
        result_d = result_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
`ifdef MULDIV_DIV_EN
        w_div_load = 1'b0;
        w_div_step = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = funct3;
                    rd_d    = rd_in;
                    cnt_d   = '0;
                    sa_d    = w_a_neg;
                    sb_d    = w_b_neg;
                    prod_d  = {{XLEN{1'b0}}, w_b_mag};
                    mcand_d = w_a_mag;
                    if (is_divrem(funct3)) begin
`ifdef MULDIV_DIV_EN
                        if (rs2_val == '0) begin
                            state_d  = ST_DONE;
                            result_d = funct3[1] ? rs1_val : {XLEN{1'b1}};
                            rd_out_d = rd_in;
                        end else begin
                            state_d    = ST_RUN;
                            w_div_load = 1'b1;
                        end
`else
                        state_d  = ST_DONE;
                        result_d = '0;
                        rd_out_d = rd_in;
`endif
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cnt_d  = cnt_q + 1'b1;
                prod_d = w_prod_step;
`ifdef MULDIV_DIV_EN
                w_div_step = is_divrem(op_q);
`endif
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    result_d = w_run_res;
                    rd_out_d = rd_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            result_q <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rd_out_q <= rd_out_d;
            result_q <= result_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

`default_nettype wire
